mo_mul_pipe: RTL

- Parametrised, fully pipelined Montgomery multiplier for the NTT butterfly datapath.
- Computes result = a·b·2^(-WIDTH) mod Q, canonical in [0,Q).
- Processes RADIX_BITS multiplier bits per stage and ends with a final-correction stage.
- Adds valid/ready flow control with backpressure and a sideband tag that travels with each operand pair, so butterfly control can stall the pipe without losing data.

---
 rtl/mo_mul_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mo_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mo_mul_pipe
//  Description : Fully pipelined Montgomery multiplier with valid/ready flow
//                control and a sideband tag. Computes a*b*2^-WIDTH mod Q,
//                canonical in [0,Q). Each iteration stage consumes
//                RADIX_BITS bits of b, and a final stage subtracts Q once.
//                The whole pipe advances together and stalls as one unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mo_mul_pipe #(
  parameter int WIDTH      = 12,
  parameter int Q          = 3329,
  parameter int RADIX_BITS = 1,
  parameter int Q_NINV     = 1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = WIDTH / RADIX_BITS;
  localparam int R      = RADIX_BITS;
  // Accumulator stays below 2Q, and the pre-shift sum below 2^(R+1)*Q.
  localparam int IW     = WIDTH + RADIX_BITS + 2;

  localparam logic [IW-1:0]    Q_IW    = IW'(Q);
  localparam logic [WIDTH-1:0] Q_W     = WIDTH'(Q);
  localparam logic [R-1:0]     QNINV_R = R'(Q_NINV);

  // Parameter sanity checks, evaluated at elaboration.
  if (RADIX_BITS < 1 || RADIX_BITS > 4) begin : g_chk_radix
    $error("mo_mul_pipe: RADIX_BITS must be in 1..4");
  end
  if ((WIDTH % RADIX_BITS) != 0) begin : g_chk_div
    $error("mo_mul_pipe: WIDTH must be a multiple of RADIX_BITS");
  end
  if ((Q % 2) == 0 || Q < 3) begin : g_chk_odd
    $error("mo_mul_pipe: Q must be odd");
  end
  if (longint'(Q) >= (longint'(1) << WIDTH)) begin : g_chk_range
    $error("mo_mul_pipe: Q must be below 2^WIDTH");
  end
  if (((longint'(Q) * longint'(Q_NINV) + 64'sd1) % (longint'(1) << RADIX_BITS)) != 0) begin : g_chk_ninv
    $error("mo_mul_pipe: Q_NINV must equal -Q^-1 mod 2^RADIX_BITS");
  end
  if (TAG_W < 1) begin : g_chk_tag
    $error("mo_mul_pipe: TAG_W must be at least 1");
  end

  // One radix-2^R Montgomery step: add d*a, add the multiple of Q that
  // clears the low R bits, then drop those (zero) bits.
  function automatic logic [IW-1:0] mont_step(
    input logic [IW-1:0]    acc,
    input logic [WIDTH-1:0] a_op,
    input logic [R-1:0]     d
  );
    logic [IW-1:0] t;
    logic [IW-1:0] u;
    logic [R-1:0]  m;
    t = acc + IW'(d) * IW'(a_op);
    m = R'(t[R-1:0] * QNINV_R);
    u = t + IW'(m) * Q_IW;
    return u >> R;
  endfunction

  logic                adv;
  logic [STAGES-1:0]   vld;
  logic [IW-1:0]       acc_q [STAGES];
  logic [IW-1:0]       acc_d [STAGES];
  logic [WIDTH-1:0]    a_q   [STAGES];
  // b_q holds only the digits not yet consumed, shifted down to bit 0.
  logic [WIDTH-1:0]    b_q   [STAGES];
  logic [TAG_W-1:0]    tag_q [STAGES];
  logic [IW-1:0]       acc_last;
  logic [WIDTH-1:0]    corr;

  // Global advance: the output slot is free or is being drained this cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Next accumulator for every iteration stage.
  always_comb begin
    acc_d[0] = mont_step('0, a, b[R-1:0]);
    for (int i = 1; i < STAGES; i++) begin
      acc_d[i] = mont_step(acc_q[i-1], a_q[i-1], b_q[i-1][R-1:0]);
    end
  end

  // Final conditional subtraction brings the accumulator into [0,Q).
  always_comb begin
    acc_last = acc_q[STAGES-1];
    corr     = WIDTH'((acc_last >= Q_IW) ? (acc_last - Q_IW) : acc_last);
  end

  // Control path: valid bits and registered outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      vld       <= STAGES'({vld, in_valid});
      out_valid <= vld[STAGES-1];
      // Hold the last result across bubbles so stale data never shows.
      if (vld[STAGES-1]) begin
        result  <= corr;
        out_tag <= tag_q[STAGES-1];
      end
    end
  end

  // Data path: accumulators, operands and tags shift on every advance.
  always_ff @(posedge clk) begin
    if (adv) begin
      acc_q[0] <= acc_d[0];
      a_q[0]   <= a;
      b_q[0]   <= b >> R;
      tag_q[0] <= in_tag;
      for (int i = 1; i < STAGES; i++) begin
        acc_q[i] <= acc_d[i];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1] >> R;
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Flag out-of-range operands on acceptance; the pipe keeps running.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      assert (a < Q_W && b < Q_W)
        else $error("mo_mul_pipe: operand >= Q accepted (a=%0d b=%0d)", a, b);
    end
  end

endmodule
`default_nettype wire
